apb_cmd_master: RTL and testbench

Parametrised, queued APB4 master that generalises the single-shot add master. Requesters push read/write commands into an internal command FIFO. The block issues them on the APB bus back-to-back and returns one response per command: read data, slave error and timeout status. It sits between the local command source (testbench or CPU-side logic) and the APB slave fabric.

---
 rtl/apb_cmd_master.sv | 192 +++++++++++++++++++
 tb/tb_apb_cmd_master.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_cmd_master.sv
// Queued APB4 master: a command FIFO feeds an IDLE/SETUP/ACCESS bus FSM,
// and every accepted command returns one response pulse, in command order.
//
// Ports:
//   pclk, preset        rising-edge clock, synchronous active-high reset
//   cmd_*               command push side (valid/ready, write, addr, wdata, strb)
//   rsp_*               one-cycle response (rdata, err, timeout), no backpressure
//   p*                  APB4 master bus signals
//   busy_o              FSM active or commands still queued (registered)
//   fifo_count_o        registered FIFO occupancy
module apb_cmd_master #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                          pclk,
    input  logic                          preset,
    input  logic                          cmd_valid_i,
    output logic                          cmd_ready_o,
    input  logic                          cmd_write_i,
    input  logic [ADDR_W-1:0]             cmd_addr_i,
    input  logic [DATA_W-1:0]             cmd_wdata_i,
    input  logic [DATA_W/8-1:0]           cmd_strb_i,
    output logic                          rsp_valid_o,
    output logic [DATA_W-1:0]             rsp_rdata_o,
    output logic                          rsp_err_o,
    output logic                          rsp_timeout_o,
    output logic                          psel_o,
    output logic                          penable_o,
    output logic [ADDR_W-1:0]             paddr_o,
    output logic                          pwrite_o,
    output logic [DATA_W-1:0]             pwdata_o,
    output logic [DATA_W/8-1:0]           pstrb_o,
    input  logic [DATA_W-1:0]             prdata_i,
    input  logic                          pready_i,
    input  logic                          pslverr_i,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

    localparam int STRB_W = DATA_W / 8;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int TO_W   = (TIMEOUT_CYCLES > 0) ?
                            $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t state, state_nxt;

    // Command FIFO storage (no reset needed: guarded by count)
    logic              q_write [FIFO_DEPTH];
    logic [ADDR_W-1:0] q_addr  [FIFO_DEPTH];
    logic [DATA_W-1:0] q_wdata [FIFO_DEPTH];
    logic [STRB_W-1:0] q_strb  [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count, count_nxt;
    logic             full, empty, push, pop;

    logic [TO_W-1:0]  to_cnt;
    logic             xfer_done, xfer_to;

    assign full        = (count == FULL_CNT);
    assign empty       = (count == '0);
    assign cmd_ready_o = !full;
    assign push        = cmd_valid_i && !full;

    always_ff @(posedge pclk) begin
        if (push) begin
            q_write[wr_ptr] <= cmd_write_i;
            q_addr[wr_ptr]  <= cmd_addr_i;
            q_wdata[wr_ptr] <= cmd_wdata_i;
            q_strb[wr_ptr]  <= cmd_strb_i;
        end
    end

    always_comb begin
        count_nxt = count;
        unique case ({push, pop})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_nxt;
        end
    end

    // Next state; a finishing ACCESS pops directly into SETUP when work is queued
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        xfer_done = 1'b0;
        xfer_to   = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = SETUP;
                end
            end
            SETUP: state_nxt = ACCESS;
            ACCESS: begin
                if (pready_i)
                    xfer_done = 1'b1;
                else if (TIMEOUT_CYCLES > 0 && to_cnt == TO_LIMIT)
                    xfer_to = 1'b1;
                if (xfer_done || xfer_to) begin
                    if (!empty) begin
                        pop       = 1'b1;
                        state_nxt = SETUP;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Holds k during the k-th ACCESS cycle
    always_ff @(posedge pclk) begin
        if (preset) begin
            to_cnt <= '0;
        end else if (state == SETUP) begin
            to_cnt <= TO_W'(1);
        end else if (state == ACCESS && !(xfer_done || xfer_to)) begin
            to_cnt <= to_cnt + TO_W'(1);
        end else begin
            to_cnt <= '0;
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            paddr_o  <= '0;
            pwrite_o <= 1'b0;
            pwdata_o <= '0;
            pstrb_o  <= '0;
        end else if (pop) begin
            paddr_o  <= q_addr[rd_ptr];
            pwrite_o <= q_write[rd_ptr];
            pwdata_o <= q_wdata[rd_ptr];
            pstrb_o  <= q_write[rd_ptr] ? q_strb[rd_ptr] : '0;
        end
    end

    assign psel_o    = (state != IDLE);
    assign penable_o = (state == ACCESS);

    always_ff @(posedge pclk) begin
        if (preset) begin
            rsp_valid_o   <= 1'b0;
            rsp_rdata_o   <= '0;
            rsp_err_o     <= 1'b0;
            rsp_timeout_o <= 1'b0;
            busy_o        <= 1'b0;
        end else begin
            rsp_valid_o   <= xfer_done || xfer_to;
            rsp_rdata_o   <= (xfer_done && !pwrite_o) ? prdata_i : '0;
            rsp_err_o     <= xfer_done ? pslverr_i : xfer_to;
            rsp_timeout_o <= xfer_to;
            busy_o        <= (state_nxt != IDLE) || (count_nxt != '0);
        end
    end

    assign fifo_count_o = count;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master: table of single transfers plus
// hand sequences for FIFO fill/drain, timeout boundary and reset.
module tb_apb_cmd_master;

    logic        pclk = 1'b0;
    logic        preset = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic        cmd_write_i = 1'b0;
    logic [31:0] cmd_addr_i = '0;
    logic [31:0] cmd_wdata_i = '0;
    logic [3:0]  cmd_strb_i = '0;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        rsp_timeout_o;
    logic        psel_o;
    logic        penable_o;
    logic [31:0] paddr_o;
    logic        pwrite_o;
    logic [31:0] pwdata_o;
    logic [3:0]  pstrb_o;
    logic [31:0] prdata_i = '0;
    logic        pready_i = 1'b0;
    logic        pslverr_i = 1'b0;
    logic        busy_o;
    logic [2:0]  fifo_count_o;

    apb_cmd_master #(
        .ADDR_W(32), .DATA_W(32), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(16)
    ) dut (
        .pclk(pclk), .preset(preset),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_write_i(cmd_write_i), .cmd_addr_i(cmd_addr_i),
        .cmd_wdata_i(cmd_wdata_i), .cmd_strb_i(cmd_strb_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
        .psel_o(psel_o), .penable_o(penable_o), .paddr_o(paddr_o),
        .pwrite_o(pwrite_o), .pwdata_o(pwdata_o), .pstrb_o(pstrb_o),
        .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i),
        .busy_o(busy_o), .fifo_count_o(fifo_count_o)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] prdata;
        int          waits;
        logic        slverr;
        logic [3:0]  exp_pstrb;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t        vecs [4];
    logic [31:0] drain_exp [5];
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s);
        cmd_valid_i = 1'b1;
        cmd_write_i = w;
        cmd_addr_i  = a;
        cmd_wdata_i = d;
        cmd_strb_i  = s;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int acc;
        push(v.write, v.addr, v.wdata, v.strb);
        tick();
        cmd_valid_i = 1'b0;
        chk($sformatf("v%0d count N+1", idx), fifo_count_o, 1);
        tick();
        chk($sformatf("v%0d setup psel", idx), psel_o, 1);
        chk($sformatf("v%0d setup penable", idx), penable_o, 0);
        chk($sformatf("v%0d busy", idx), busy_o, 1);
        tick();
        acc = 0;
        for (int k = 0; k <= v.waits; k++) begin
            if (psel_o && penable_o) acc++;
            chk($sformatf("v%0d paddr", idx), paddr_o, v.addr);
            chk($sformatf("v%0d pwrite", idx), pwrite_o, v.write);
            chk($sformatf("v%0d pstrb", idx), pstrb_o, v.exp_pstrb);
            if (v.write)
                chk($sformatf("v%0d pwdata", idx), pwdata_o, v.wdata);
            pready_i  = (k == v.waits);
            pslverr_i = (k == v.waits) ? v.slverr : 1'b0;
            prdata_i  = (k == v.waits) ? v.prdata : 32'h0;
            tick();
        end
        pready_i  = 1'b0;
        pslverr_i = 1'b0;
        chk($sformatf("v%0d access cycles", idx), acc, v.waits + 1);
        chk($sformatf("v%0d rsp_valid", idx), rsp_valid_o, 1);
        chk($sformatf("v%0d rsp_rdata", idx), rsp_rdata_o, v.exp_rdata);
        chk($sformatf("v%0d rsp_err", idx), rsp_err_o, v.exp_err);
        chk($sformatf("v%0d rsp_timeout", idx), rsp_timeout_o, 0);
        chk($sformatf("v%0d idle psel", idx), psel_o, 0);
        chk($sformatf("v%0d idle busy", idx), busy_o, 0);
        tick();
        chk($sformatf("v%0d rsp pulse", idx), rsp_valid_o, 0);
    endtask

    initial begin
        int acc, nrsp, gaps, pulses;
        logic got;

        vecs[0] = '{1'b1, 32'h0000_A000, 32'hDEAD_BEEF, 4'hF, 32'h5555_5555,
                    0, 1'b0, 4'hF, 32'h0, 1'b0};
        vecs[1] = '{1'b0, 32'h0000_1004, 32'h0, 4'hF, 32'h1234_5678,
                    2, 1'b0, 4'h0, 32'h1234_5678, 1'b0};
        vecs[2] = '{1'b0, 32'h0000_2000, 32'h0, 4'h3, 32'hCAFE_F00D,
                    0, 1'b1, 4'h0, 32'hCAFE_F00D, 1'b1};
        vecs[3] = '{1'b1, 32'h0000_3008, 32'h0BAD_F00D, 4'h5, 32'h7777_7777,
                    1, 1'b1, 4'h5, 32'h0, 1'b1};

        tick();
        tick();
        preset = 1'b0;
        tick();
        chk("reset cmd_ready", cmd_ready_o, 1);
        chk("reset psel", psel_o, 0);
        chk("reset penable", penable_o, 0);
        chk("reset rsp_valid", rsp_valid_o, 0);
        chk("reset busy", busy_o, 0);
        chk("reset count", fifo_count_o, 0);
        chk("reset paddr", paddr_o, 0);

        for (int i = 0; i < 4; i++) run_vec(vecs[i], i);

        // Fill: 6 pushes with the slave stalled; one goes to the bus,
        // four fill the FIFO and the sixth is dropped.
        for (int i = 0; i < 6; i++) begin
            push(1'b0, 32'h0000_5000 + 32'(i * 4), 32'h0, 4'hF);
            if (i == 5) chk("fill ready at 6th", cmd_ready_o, 0);
            tick();
        end
        cmd_valid_i = 1'b0;
        chk("fill count", fifo_count_o, 4);
        chk("fill cmd_ready", cmd_ready_o, 0);
        chk("fill penable", penable_o, 1);

        // Drain: slave answers {D0D0, addr[15:0]}
        for (int i = 0; i < 5; i++)
            drain_exp[i] = {16'hD0D0, 16'h5000 + 16'(i * 4)};
        pready_i = 1'b1;
        prdata_i = {16'hD0D0, paddr_o[15:0]};
        nrsp = 0;
        gaps = 0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            prdata_i = {16'hD0D0, paddr_o[15:0]};
            if (c <= 8 && !psel_o) gaps++;
            if (rsp_valid_o) begin
                if (nrsp < 5) begin
                    chk("drain rdata", rsp_rdata_o, drain_exp[nrsp]);
                    chk("drain spacing", c, 1 + 2 * nrsp);
                end
                nrsp++;
            end
        end
        pready_i = 1'b0;
        prdata_i = '0;
        chk("drain responses", nrsp, 5);
        chk("drain idle gaps", gaps, 0);
        chk("drain count", fifo_count_o, 0);

        // Timeout: read stalls, queued write follows with no IDLE bubble
        prdata_i = 32'hFFFF_FFFF;
        push(1'b0, 32'h0000_4000, 32'h0, 4'hF);
        tick();
        push(1'b1, 32'h0000_4004, 32'h1111_2222, 4'hF);
        tick();
        cmd_valid_i = 1'b0;
        acc = 0;
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            tick();
            if (rsp_valid_o) got = 1'b1;
            else if (penable_o) acc++;
        end
        chk("timeout seen", got, 1);
        chk("timeout access cycles", acc, 16);
        chk("timeout err", rsp_err_o, 1);
        chk("timeout flag", rsp_timeout_o, 1);
        chk("timeout rdata", rsp_rdata_o, 0);
        chk("timeout next setup", {psel_o, penable_o}, 2'b10);
        chk("timeout next paddr", paddr_o, 32'h0000_4004);
        pready_i = 1'b1;
        prdata_i = 32'h0;
        tick();
        chk("post-timeout access", penable_o, 1);
        tick();
        pready_i = 1'b0;
        chk("post-timeout rsp", rsp_valid_o, 1);
        chk("post-timeout err", rsp_err_o, 0);
        chk("post-timeout flag", rsp_timeout_o, 0);
        tick();

        // pready in the 16th ACCESS cycle completes normally
        push(1'b0, 32'h0000_6000, 32'h0, 4'hF);
        tick();
        cmd_valid_i = 1'b0;
        tick();
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 16) begin
                chk("edge access", penable_o, 1);
                pready_i = 1'b1;
                prdata_i = 32'hA5A5_0016;
            end
        end
        tick();
        pready_i = 1'b0;
        prdata_i = '0;
        chk("edge rsp", rsp_valid_o, 1);
        chk("edge err", rsp_err_o, 0);
        chk("edge timeout", rsp_timeout_o, 0);
        chk("edge rdata", rsp_rdata_o, 32'hA5A5_0016);
        tick();

        // Reset during ACCESS with two commands queued
        for (int i = 0; i < 3; i++) begin
            push(1'b1, 32'h0000_7000 + 32'(i * 4), 32'h0, 4'hF);
            tick();
        end
        cmd_valid_i = 1'b0;
        chk("pre-reset access", penable_o, 1);
        chk("pre-reset count", fifo_count_o, 2);
        preset = 1'b1;
        tick();
        preset = 1'b0;
        chk("reset psel", psel_o, 0);
        chk("reset penable", penable_o, 0);
        chk("reset count", fifo_count_o, 0);
        chk("reset ready", cmd_ready_o, 1);
        chk("reset rsp", rsp_valid_o, 0);
        pready_i = 1'b1;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (rsp_valid_o || psel_o) pulses++;
        end
        pready_i = 1'b0;
        chk("no activity after reset", pulses, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
